// File: rtl/d_cache_pkg.sv
// d_cache_pkg
//   Shared types and width helpers for the D-cache data store.
//   dc_state_e : sequencer states (idle / refill / evict read / evict hold)
//   dc_be_w    : byte-enable width for a given word width
//   dc_way_w   : way-select width for a given way count
//   dc_addr_w  : bank address width ({set, word})
package d_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_EV_RD   = 2'd2,
    ST_EV_HOLD = 2'd3
  } dc_state_e;

  function automatic int dc_be_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int dc_way_w(input int ways);
    return $clog2(ways);
  endfunction

  function automatic int dc_addr_w(input int set_bits, input int beat_bits);
    return set_bits + beat_bits;
  endfunction

endpackage

// File: rtl/d_cache_data_bank.sv
// d_cache_data_bank
//   One way of the data store: 2**ADDR_W words of DATA_W, byte-enable write,
//   registered read. Read returns the contents before any same-cycle write.
//   clk    : clock
//   en     : access this cycle (read always, write where we bits are set)
//   we     : byte write enables
//   addr   : word address {set, word}
//   wdata  : write data
//   rdata  : registered read data, holds when en is low
module d_cache_data_bank
  import d_cache_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int BE_W  = dc_be_w(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int b = 0; b < BE_W; b++) begin
        if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/d_cache_data_array.sv
// d_cache_data_array
//   N-way D-cache data store with a beat-serial refill / evict sequencer.
//   All ways are read in parallel on a core access; the hit mux is external.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | core port owns the banks; waiting for fill/evict start
//   ST_FILL    | accepting refill beats into {way_q, set_q, cnt_q}
//   ST_EV_RD   | reading evict word cnt_q of the latched way
//   ST_EV_HOLD | presenting evict beat until evict_ready_i
//
//   Ports
//   clk, rst                 : clock, synchronous active-high reset
//   core_req_i .. wdata_i    : core access (we all-zero = read)
//   core_stall_o             : request not accepted this cycle
//   core_rvalid_o/rdata_o    : all-way read data one cycle after acceptance
//   fill_start_i/way/set     : begin refill of a line
//   fill_valid_i/data_i      : refill beat, taken when fill_ready_o
//   fill_done_o              : pulse the cycle after the last beat is written
//   evict_start_i/way/set    : begin evict of a line
//   evict_valid_o/data_o     : evict beat, held until evict_ready_i
//   evict_done_o             : pulse on the last beat handshake
module d_cache_data_array
  import d_cache_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int WAYS      = 2,
  parameter int SET_BITS  = 6,
  parameter int BEAT_BITS = 1,
  localparam int BE_W     = dc_be_w(DATA_W),
  localparam int WAY_W    = dc_way_w(WAYS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_req_i,
  input  logic [BE_W-1:0]         core_we_i,
  input  logic [WAY_W-1:0]        core_way_i,
  input  logic [SET_BITS-1:0]     core_set_i,
  input  logic [BEAT_BITS-1:0]    core_word_i,
  input  logic [DATA_W-1:0]       core_wdata_i,
  output logic                    core_stall_o,
  output logic                    core_rvalid_o,
  output logic [WAYS*DATA_W-1:0]  core_rdata_o,
  input  logic                    fill_start_i,
  input  logic [WAY_W-1:0]        fill_way_i,
  input  logic [SET_BITS-1:0]     fill_set_i,
  input  logic                    fill_valid_i,
  input  logic [DATA_W-1:0]       fill_data_i,
  output logic                    fill_ready_o,
  output logic                    fill_done_o,
  input  logic                    evict_start_i,
  input  logic [WAY_W-1:0]        evict_way_i,
  input  logic [SET_BITS-1:0]     evict_set_i,
  output logic                    evict_valid_o,
  output logic [DATA_W-1:0]       evict_data_o,
  input  logic                    evict_ready_i,
  output logic                    evict_done_o
);

  localparam int ADDR_W = dc_addr_w(SET_BITS, BEAT_BITS);
  localparam logic [BEAT_BITS-1:0] BEAT_LAST = '1;

  dc_state_e              state_q, state_d;
  logic [BEAT_BITS-1:0]   cnt_q;
  logic [WAY_W-1:0]       way_q;
  logic [SET_BITS-1:0]    set_q;
  logic                   fill_done_q;
  logic                   rvalid_q;
  logic [WAYS*DATA_W-1:0] hold_q;
  logic [WAYS*DATA_W-1:0] rd_all;

  logic                   bank_en    [WAYS];
  logic [BE_W-1:0]        bank_we    [WAYS];
  logic [ADDR_W-1:0]      bank_addr  [WAYS];
  logic [DATA_W-1:0]      bank_wdata [WAYS];
  logic [DATA_W-1:0]      bank_rdata [WAYS];

  logic core_acc, fill_beat, ev_hs, last_beat;

  assign core_acc  = core_req_i & ~core_stall_o;
  assign fill_beat = (state_q == ST_FILL) & fill_valid_i;
  assign ev_hs     = (state_q == ST_EV_HOLD) & evict_ready_i;
  assign last_beat = (cnt_q == BEAT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; evict has priority when both starts arrive together
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (evict_start_i)     state_d = ST_EV_RD;
        else if (fill_start_i) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (fill_valid_i && last_beat) state_d = ST_IDLE;
      end
      ST_EV_RD:   state_d = ST_EV_HOLD;
      ST_EV_HOLD: begin
        if (evict_ready_i) state_d = last_beat ? ST_IDLE : ST_EV_RD;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    core_stall_o  = (state_q != ST_IDLE) | fill_start_i | evict_start_i;
    fill_ready_o  = (state_q == ST_FILL);
    fill_done_o   = fill_done_q;
    evict_valid_o = (state_q == ST_EV_HOLD);
    evict_done_o  = ev_hs & last_beat;
    evict_data_o  = evict_valid_o ? bank_rdata[way_q] : '0;
    core_rvalid_o = rvalid_q;
    // Banks also move on fill/evict traffic, so the core view comes from
    // a hold copy once the read-valid cycle has passed.
    core_rdata_o  = rvalid_q ? rd_all : hold_q;
  end

  always_comb begin
    rd_all = '0;
    for (int w = 0; w < WAYS; w++) rd_all[w*DATA_W +: DATA_W] = bank_rdata[w];
  end

  // Beat counter, line latch, read-valid and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      way_q       <= '0;
      set_q       <= '0;
      fill_done_q <= 1'b0;
      rvalid_q    <= 1'b0;
      hold_q      <= '0;
    end else begin
      fill_done_q <= fill_beat & last_beat;
      rvalid_q    <= core_acc;
      if (rvalid_q) hold_q <= rd_all;
      if (state_q == ST_IDLE) begin
        cnt_q <= '0;
        if (evict_start_i) begin
          way_q <= evict_way_i;
          set_q <= evict_set_i;
        end else if (fill_start_i) begin
          way_q <= fill_way_i;
          set_q <= fill_set_i;
        end
      end else if (fill_beat || ev_hs) begin
        cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
      end
    end
  end

  // Bank port mux: core in idle, otherwise the sequencer on the latched way
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      bank_en[w]    = 1'b0;
      bank_we[w]    = '0;
      bank_addr[w]  = {set_q, cnt_q};
      bank_wdata[w] = fill_data_i;
      case (state_q)
        ST_IDLE: begin
          if (core_acc) begin
            bank_en[w]    = 1'b1;
            bank_addr[w]  = {core_set_i, core_word_i};
            bank_wdata[w] = core_wdata_i;
            if (core_way_i == WAY_W'(w)) bank_we[w] = core_we_i;
          end
        end
        ST_FILL: begin
          if (fill_valid_i && way_q == WAY_W'(w)) begin
            bank_en[w] = 1'b1;
            bank_we[w] = '1;
          end
        end
        ST_EV_RD: begin
          if (way_q == WAY_W'(w)) bank_en[w] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_bank
    d_cache_data_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk   (clk),
      .en    (bank_en[g]),
      .we    (bank_we[g]),
      .addr  (bank_addr[g]),
      .wdata (bank_wdata[g]),
      .rdata (bank_rdata[g])
    );
  end

endmodule

// File: tb/tb_d_cache_data_array.sv
module tb_d_cache_data_array;

  localparam int DATA_W    = 64;
  localparam int WAYS      = 2;
  localparam int SET_BITS  = 6;
  localparam int BEAT_BITS = 1;
  localparam int BE_W      = DATA_W / 8;
  localparam int WAY_W     = 1;
  localparam int WORDS     = 2 ** BEAT_BITS;
  localparam int SETS      = 2 ** SET_BITS;
  localparam int VW        = WAYS * DATA_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 core_req = 1'b0;
  logic [BE_W-1:0]      core_we = '0;
  logic [WAY_W-1:0]     core_way = '0;
  logic [SET_BITS-1:0]  core_set = '0;
  logic [BEAT_BITS-1:0] core_word = '0;
  logic [DATA_W-1:0]    core_wdata = '0;
  logic                 core_stall, core_rvalid;
  logic [VW-1:0]        core_rdata;
  logic                 fill_start = 1'b0;
  logic [WAY_W-1:0]     fill_way = '0;
  logic [SET_BITS-1:0]  fill_set = '0;
  logic                 fill_valid = 1'b0;
  logic [DATA_W-1:0]    fill_data = '0;
  logic                 fill_ready, fill_done;
  logic                 evict_start = 1'b0;
  logic [WAY_W-1:0]     evict_way = '0;
  logic [SET_BITS-1:0]  evict_set = '0;
  logic                 evict_valid;
  logic [DATA_W-1:0]    evict_data;
  logic                 evict_ready = 1'b0;
  logic                 evict_done;

  always #5 clk = ~clk;

  d_cache_data_array #(
    .DATA_W(DATA_W), .WAYS(WAYS), .SET_BITS(SET_BITS), .BEAT_BITS(BEAT_BITS)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_way_i(core_way),
    .core_set_i(core_set), .core_word_i(core_word), .core_wdata_i(core_wdata),
    .core_stall_o(core_stall), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .fill_start_i(fill_start), .fill_way_i(fill_way), .fill_set_i(fill_set),
    .fill_valid_i(fill_valid), .fill_data_i(fill_data),
    .fill_ready_o(fill_ready), .fill_done_o(fill_done),
    .evict_start_i(evict_start), .evict_way_i(evict_way), .evict_set_i(evict_set),
    .evict_valid_o(evict_valid), .evict_data_o(evict_data),
    .evict_ready_i(evict_ready), .evict_done_o(evict_done)
  );

  // Reference model: one flat word array per way, plus a known flag per word
  logic [DATA_W-1:0] ref_mem   [WAYS][SETS*WORDS];
  bit                ref_known [WAYS][SETS*WORDS];
  logic [VW-1:0]     last_exp, last_mask;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int lidx(input int set, input int word);
    return set * WORDS + word;
  endfunction

  function automatic logic [VW-1:0] exp_vec(input int set, input int word);
    logic [VW-1:0] v = '0;
    for (int w = 0; w < WAYS; w++) v[w*DATA_W +: DATA_W] = ref_mem[w][lidx(set, word)];
    return v;
  endfunction

  function automatic logic [VW-1:0] mask_vec(input int set, input int word);
    logic [VW-1:0] v = '0;
    for (int w = 0; w < WAYS; w++)
      if (ref_known[w][lidx(set, word)]) v[w*DATA_W +: DATA_W] = '1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_access(input int way, input int set, input int word,
                             input logic [BE_W-1:0] we, input logic [DATA_W-1:0] data);
    logic [VW-1:0] e, m;
    int i;
    core_req = 1'b1; core_way = WAY_W'(way); core_set = SET_BITS'(set);
    core_word = BEAT_BITS'(word); core_we = we; core_wdata = data;
    #1;
    chk("core_stall_idle", core_stall, 1'b0);
    e = exp_vec(set, word);
    m = mask_vec(set, word);
    tick();
    core_req = 1'b0;
    chk("core_rvalid", core_rvalid, 1'b1);
    chk("core_rdata", core_rdata & m, e & m);
    i = lidx(set, word);
    for (int b = 0; b < BE_W; b++)
      if (we[b]) ref_mem[way][i][b*8 +: 8] = data[b*8 +: 8];
    if (we == '1) ref_known[way][i] = 1'b1;
    last_exp = e; last_mask = m;
  endtask

  task automatic idle_check();
    tick();
    chk("rvalid_idle", core_rvalid, 1'b0);
    chk("rdata_hold", core_rdata & last_mask, last_exp & last_mask);
  endtask

  // g_first / g_rest: idle cycles before the first / later beats (-1 = random 0..3)
  task automatic do_fill(input int way, input int set, input int g_first, input int g_rest);
    int g;
    logic [DATA_W-1:0] d;
    fill_start = 1'b1; fill_way = WAY_W'(way); fill_set = SET_BITS'(set);
    #1;
    chk("fill_start_stall", core_stall, 1'b1);
    tick();
    fill_start = 1'b0;
    for (int beat = 0; beat < WORDS; beat++) begin
      g = (beat == 0) ? g_first : g_rest;
      if (g < 0) g = $urandom_range(0, 3);
      repeat (g) begin
        fill_valid = 1'b0;
        fill_data  = {$urandom, $urandom};
        chk("fill_ready_gap", fill_ready, 1'b1);
        chk("fill_done_gap", fill_done, 1'b0);
        chk("fill_core_hold", core_rdata & last_mask, last_exp & last_mask);
        tick();
      end
      d = {$urandom, $urandom};
      fill_valid = 1'b1; fill_data = d;
      #1;
      chk("fill_ready_beat", fill_ready, 1'b1);
      chk("fill_stall", core_stall, 1'b1);
      tick();
      fill_valid = 1'b0;
      ref_mem[way][lidx(set, beat)]   = d;
      ref_known[way][lidx(set, beat)] = 1'b1;
      chk("fill_done_pulse", fill_done, (beat == WORDS - 1));
    end
    chk("fill_ready_exit", fill_ready, 1'b0);
    idle_check();
    chk("fill_done_clear", fill_done, 1'b0);
  endtask

  // busy: hold a conflicting core write plus a fill start against the evict
  task automatic do_evict(input int way, input int set, input int d_first, input int d_rest,
                          input bit busy);
    int d;
    logic [DATA_W-1:0] e, m;
    evict_start = 1'b1; evict_way = WAY_W'(way); evict_set = SET_BITS'(set);
    if (busy) begin
      fill_start = 1'b1; fill_way = WAY_W'(way ^ 1); fill_set = SET_BITS'(set);
      core_req = 1'b1; core_way = WAY_W'(way); core_set = SET_BITS'(set);
      core_word = '0; core_we = '1; core_wdata = {$urandom, $urandom};
    end
    #1;
    chk("evict_start_stall", core_stall, 1'b1);
    tick();
    evict_start = 1'b0; fill_start = 1'b0;
    for (int beat = 0; beat < WORDS; beat++) begin
      chk("evict_valid_rd", evict_valid, 1'b0);
      chk("evict_fill_ready", fill_ready, 1'b0);
      if (busy) begin
        chk("busy_stall", core_stall, 1'b1);
        chk("busy_rvalid", core_rvalid, 1'b0);
      end
      tick();
      e = ref_mem[way][lidx(set, beat)];
      m = ref_known[way][lidx(set, beat)] ? '1 : '0;
      d = (beat == 0) ? d_first : d_rest;
      if (d < 0) d = $urandom_range(0, 3);
      repeat (d) begin
        chk("evict_valid_wait", evict_valid, 1'b1);
        chk("evict_data_wait", evict_data & m, e & m);
        chk("evict_done_wait", evict_done, 1'b0);
        if (busy) chk("busy_stall_hold", core_stall, 1'b1);
        tick();
      end
      evict_ready = 1'b1;
      #1;
      chk("evict_valid_hs", evict_valid, 1'b1);
      chk("evict_data_hs", evict_data & m, e & m);
      chk("evict_done_hs", evict_done, (beat == WORDS - 1));
      tick();
      evict_ready = 1'b0;
      if (busy && beat == WORDS - 1) core_req = 1'b0;
    end
    chk("evict_valid_exit", evict_valid, 1'b0);
    chk("evict_done_exit", evict_done, 1'b0);
    chk("evict_stall_exit", core_stall, 1'b0);
    idle_check();
  endtask

  initial begin
    int op, w, s, wd;
    logic [BE_W-1:0] we;
    logic [DATA_W-1:0] dat;

    for (int i = 0; i < WAYS; i++)
      for (int j = 0; j < SETS * WORDS; j++) begin
        ref_mem[i][j] = '0; ref_known[i][j] = 1'b0;
      end
    last_exp = '0; last_mask = '1;

    repeat (3) tick();
    chk("rst_stall", core_stall, 1'b0);
    chk("rst_rvalid", core_rvalid, 1'b0);
    chk("rst_rdata", core_rdata, '0);
    chk("rst_fill_ready", fill_ready, 1'b0);
    chk("rst_fill_done", fill_done, 1'b0);
    chk("rst_evict_valid", evict_valid, 1'b0);
    chk("rst_evict_data", evict_data, '0);
    chk("rst_evict_done", evict_done, 1'b0);
    rst = 1'b0;
    idle_check();

    // Load known contents everywhere
    for (int i = 0; i < WAYS; i++)
      for (int j = 0; j < SETS * WORDS; j++)
        core_access(i, j / WORDS, j % WORDS, '1, {$urandom, $urandom});

    // Partial byte write, then read back
    core_access(1, 5, 1, 8'h0F, 64'h1122334455667788);
    core_access(0, 5, 1, '0, '0);
    chk("byte_write_low", core_rdata[DATA_W +: 32], 32'h55667788);
    idle_check();

    // Back-to-back writes, second sees first
    core_access(0, 9, 0, '1, {8{8'hAA}});
    core_access(0, 9, 0, '1, {8{8'hBB}});
    chk("rbw_const", core_rdata[0 +: DATA_W], {8{8'hAA}});
    core_access(0, 9, 0, '0, '0);
    chk("rbw_after", core_rdata[0 +: DATA_W], {8{8'hBB}});

    // Refill way0 set63 with a 3-cycle gap between beats
    do_fill(0, 63, 0, 3);
    core_access(0, 63, 0, '0, '0);
    core_access(0, 63, 1, '0, '0);

    // Evict way1 set2, downstream stalls beat0 for 4 cycles
    do_evict(1, 2, 4, 0, 1'b0);

    // Both starts with a core write pending: evict wins, core write is dropped
    do_evict(0, 7, 1, 2, 1'b1);
    chk("both_fill_ignored", fill_ready, 1'b0);
    core_access(0, 7, 0, '0, '0);

    // Reset during refill after beat0
    fill_start = 1'b1; fill_way = 1'b1; fill_set = SET_BITS'(20);
    tick();
    fill_start = 1'b0; fill_valid = 1'b1; fill_data = {$urandom, $urandom};
    tick();
    fill_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int b = 0; b < WORDS; b++) ref_known[1][lidx(20, b)] = 1'b0;
    last_exp = '0; last_mask = '1;
    chk("rfill_ready", fill_ready, 1'b0);
    chk("rfill_done", fill_done, 1'b0);
    chk("rfill_stall", core_stall, 1'b0);
    chk("rfill_rdata", core_rdata, '0);
    core_access(0, 20, 0, '0, '0);
    chk("rfill_done_after", fill_done, 1'b0);
    idle_check();

    // Random mix
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 9);
      w  = $urandom_range(0, WAYS - 1);
      s  = $urandom_range(0, SETS - 1);
      wd = $urandom_range(0, WORDS - 1);
      we = ($urandom_range(0, 2) == 0) ? '0 : BE_W'($urandom);
      dat = {$urandom, $urandom};
      case (op)
        6: idle_check();
        7: do_fill(w, s, -1, -1);
        8: do_evict(w, s, -1, -1, 1'b0);
        9: begin
          core_access(w, s, wd, we, dat);
          core_access($urandom_range(0, WAYS - 1), s, wd, BE_W'($urandom), {$urandom, $urandom});
        end
        default: core_access(w, s, wd, we, dat);
      endcase
    end
    idle_check();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
